muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg                                                         |
// | Shared op/state encodings and a conditional negate helper.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package muldiv_pkg;

  localparam int c_maxWidth = 256;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldivOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldivState_t;

  // Operates at a fixed maximum width; callers zero-extend and truncate,
  // which is exact for two's-complement negation modulo any smaller width.
  function automatic logic [c_maxWidth-1:0] condNeg(input logic neg,
                                                    input logic [c_maxWidth-1:0] x);
    return neg ? -x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_unit                                                        |
// | Iterative signed/unsigned multiply and divide with HI/LO registers.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_cntWidth = $clog2(WIDTH + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4 || 2 * WIDTH > c_maxWidth) begin : g_widthCheck
      $error("muldiv_unit: WIDTH must be even, >= 4 and <= c_maxWidth/2");
    end
  endgenerate

  muldivState_t            r_state, w_nextState;
  logic                    r_isDiv, r_signA, r_signB, r_divZero;
  logic [c_cntWidth-1:0]   r_count;
  logic [WIDTH-1:0]        r_operand, r_hi, r_lo;
  logic [2*WIDTH-1:0]      r_work, w_workNext, w_prod;
  logic [WIDTH:0]          w_mulSum, w_divDiff;
  logic [WIDTH-1:0]        w_absA, w_absB, w_quot, w_rem;
  muldivOp_t               w_opIn;
  logic                    w_isDivIn, w_signedIn, w_negA, w_negB, w_bZero, w_idle, w_accept;

  assign w_opIn     = muldivOp_t'(op);
  assign w_isDivIn  = (w_opIn == OP_DIV) || (w_opIn == OP_DIVU);
  assign w_signedIn = (w_opIn == OP_MULT) || (w_opIn == OP_DIV);
  assign w_negA     = w_signedIn & a[WIDTH-1];
  assign w_negB     = w_signedIn & b[WIDTH-1];
  assign w_absA     = WIDTH'(condNeg(w_negA, c_maxWidth'(a)));
  assign w_absB     = WIDTH'(condNeg(w_negB, c_maxWidth'(b)));
  assign w_bZero    = (b == '0);
  assign w_idle     = (r_state == IDLE) || (r_state == DONE);
  assign w_accept   = start && w_idle;

  assign w_prod = (2*WIDTH)'(condNeg(r_signA ^ r_signB, c_maxWidth'(r_work)));
  assign w_quot = WIDTH'(condNeg(r_signA ^ r_signB, c_maxWidth'(r_work[WIDTH-1:0])));
  assign w_rem  = WIDTH'(condNeg(r_signA, c_maxWidth'(r_work[2*WIDTH-1:WIDTH])));

  assign hi = r_hi;
  assign lo = r_lo;

  // Working register: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  always_comb begin
    w_mulSum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, r_operand};
    w_divDiff = r_work[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
    w_workNext = {1'b0, r_work[2*WIDTH-1:1]};
    if (r_isDiv) begin
      if (w_divDiff[WIDTH]) begin
        w_workNext = {r_work[2*WIDTH-2:0], 1'b0};
      end else begin
        w_workNext = {w_divDiff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
      end
    end else if (r_work[0]) begin
      w_workNext = {w_mulSum, r_work[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    div_zero    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE) begin
          done     = 1'b1;
          div_zero = r_divZero;
        end
        if (start) begin
          w_nextState = (w_isDivIn && w_bZero) ? DONE : RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == c_cntWidth'(1)) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_divZero <= 1'b0;
      r_operand <= '0;
      r_work    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_isDiv   <= w_isDivIn;
        r_signA   <= w_negA;
        r_signB   <= w_negB;
        r_divZero <= w_isDivIn & w_bZero;
        r_count   <= c_cntWidth'(WIDTH);
        r_operand <= w_isDivIn ? w_absB : w_absA;
        r_work    <= {{WIDTH{1'b0}}, (w_isDivIn ? w_absA : w_absB)};
      end else if (w_idle) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end else if (r_state == RUN) begin
        r_work  <= w_workNext;
        r_count <= r_count - c_cntWidth'(1);
      end else begin
        if (r_isDiv) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_unit                                                     |
// | Directed scoreboard bench for muldiv_unit at WIDTH=32.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op    = 2'b00;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             hi_we = 1'b0;
  logic             lo_we = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] hi, lo;

  typedef struct {
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;
    logic             expDz;
    int               expCyc;
    string            name;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   cyc     = 0;
  int   nVec    = 0;
  int   nMis    = 0;
  bit   sawBusy = 1'b0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    if (busy) sawBusy = 1'b1;
    if (reset && done) begin
      if (sb.size() == 0) begin
        nVec++;
        nMis++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        monE = sb.pop_front();
        check({monE.name, "_hi"},  64'(hi),       64'(monE.expHi));
        check({monE.name, "_lo"},  64'(lo),       64'(monE.expLo));
        check({monE.name, "_dz"},  64'(div_zero), 64'(monE.expDz));
        check({monE.name, "_cyc"}, 64'(cyc),      64'(monE.expCyc));
      end
    end
  end

  task automatic waitDrain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      nVec++;
      nMis++;
      $display("FAIL %s_timeout: got no done within 100 cycles, expected completion", name);
      sb.delete();
    end
  endtask

  task automatic doOp(input logic [1:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el, input logic edz,
                      input logic alsoHiWe, input string name);
    exp_t e;
    @(posedge clock); #1;
    start = 1'b1; op = o; a = av; b = bv;
    hi_we = alsoHiWe; wdata = 32'h0000BEEF;
    e.expHi  = eh;
    e.expLo  = el;
    e.expDz  = edz;
    e.expCyc = cyc + (edz ? 1 : WIDTH + 2);
    e.name   = name;
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0;
    waitDrain(name);
  endtask

  initial begin
    exp_t e;
    int   n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_zero), 64'd0);
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, "multu_max");
    doOp(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, "mult_neg3x5");
    doOp(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, "div_neg7by2");
    doOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "div_minbym1");
    doOp(2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 1'b0, "mult_7xneg6");
    doOp(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, "divu_100by7");
    doOp(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0, "div_7byneg2");
    doOp(2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 1'b0, "multu_2p32");

    @(posedge clock); #1;
    hi_we = 1'b1; wdata = 32'h00001234;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00005678;
    @(posedge clock); #1;
    lo_we = 1'b0;
    @(negedge clock);
    check("mthi", 64'(hi), 64'h1234);
    check("mtlo", 64'(lo), 64'h5678);

    sawBusy = 1'b0;
    doOp(2'b11, 32'd10, 32'd0, 32'h1234, 32'h5678, 1'b1, 1'b0, "divu_by0");
    check("divu_by0_busy", 64'(sawBusy), 64'd0);
    doOp(2'b11, 32'd5,  32'd0, 32'h1234, 32'h5678, 1'b1, 1'b1, "divu_by0_hiwe");
    doOp(2'b10, 32'hFFFFFFFB, 32'd0, 32'h1234, 32'h5678, 1'b1, 1'b0, "div_by0");

    // Intruding start and lo_we while the first multiply is running.
    @(posedge clock); #1;
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    e.expHi = 32'd0; e.expLo = 32'd12; e.expDz = 1'b0; e.expCyc = cyc + WIDTH + 2; e.name = "busy_ignore";
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock); #1;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0; lo_we = 1'b1; wdata = 32'hFFFF;
    @(posedge clock); #1;
    start = 1'b0; lo_we = 1'b0;
    waitDrain("busy_ignore");

    // Reset asserted in the 10th RUN cycle aborts the operation.
    @(posedge clock); #1;
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'h7;
    n = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("abort_cycle", 64'(cyc), 64'(n + 10));
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi",   64'(hi), 64'd0);
    check("abort_lo",   64'(lo), 64'd0);
    repeat (50) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
